// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: decoupling FIFO between the fetch and decode stages.
// Holds {pc, inst} pairs. Fetch is backpressured when the queue is full, and
// all in-flight entries are dropped on a redirect (flush).
// Optional build macro IFQ_BYPASS_EN enables fall-through: when the queue is
// empty, a pushed entry appears on the pop side in the same cycle.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_inst,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [31:0]      pop_pc,
  output logic [31:0]      pop_inst,
  input  logic             pop_ready,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic bypass_hit;   // empty queue presenting a fall-through entry this cycle
  logic bypass_take;  // fall-through entry consumed directly by decode
  logic write_en;
  logic read_en;

  // Status flags come straight from the occupancy register, so push_ready
  // never depends on pop_ready: a full queue refuses a push even if a pop
  // happens in the same cycle.
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push_ready = !full;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = empty && push_valid && !flush && !rst;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && pop_ready;
  assign write_en    = push_valid && push_ready && !bypass_take;
  assign read_en     = !empty && pop_ready;

  // Head entry (or fall-through entry) presented to decode; zero when empty.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    pop_valid = !empty;
    pop_pc    = '0;
    pop_inst  = '0;
    if (!empty) begin
      {pop_pc, pop_inst} = mem[rd_ptr];
    end else if (bypass_hit) begin
      pop_valid = 1'b1;
      pop_pc    = push_pc;
      pop_inst  = push_inst;
    end
  end

  // Entry storage: written at wr_ptr on an accepted, non-bypassed push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count and the pointers alone
    // decide which entries are live, so stale contents are never observed.
    if (!rst && !flush && write_en) begin
      mem[wr_ptr] <= {push_pc, push_inst};
    end
  end

  // Pointer and occupancy update with priority rst > flush > push/pop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (read_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({write_en, read_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=4). A table of per-cycle
// stimulus records carries hand-derived occupancy after each edge; a queue
// scoreboard holds the {pc, inst} entries expected on the pop side.
module tb_inst_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_inst = '0;
  logic        push_ready;
  logic        pop_valid;
  logic [31:0] pop_pc;
  logic [31:0] pop_inst;
  logic        pop_ready = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_inst  (push_inst),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_pc     (pop_pc),
    .pop_inst   (pop_inst),
    .pop_ready  (pop_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        flush;
    bit        pv;
    logic [31:0] pc;
    logic [31:0] inst;
    bit        pr;
    int        exp_count;  // occupancy expected after the edge
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q[$];     // scoreboard of entries awaiting pop
  bit          known = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record one cycle; the expected count differs only where fall-through applies.
  task automatic add(input bit r, input bit f, input bit pv, input logic [31:0] pc,
                     input logic [31:0] inst, input bit pr, input int cnt_nb, input int cnt_b);
    vec_t v;
    v.rst = r; v.flush = f; v.pv = pv; v.pc = pc; v.inst = inst; v.pr = pr;
    v.exp_count = BYP ? cnt_b : cnt_nb;
    vecs.push_back(v);
  endtask

  // Apply one cycle: entered and left at a falling edge.
  task automatic step(input vec_t v);
    int          n;
    bit          e_valid;
    bit          bypassed;
    logic [63:0] e_data;
    rst = v.rst; flush = v.flush; push_valid = v.pv;
    push_pc = v.pc; push_inst = v.inst; pop_ready = v.pr;
    #1;
    n = sb_q.size();
    e_valid = (n > 0) || (BYP && v.pv && !v.flush && !v.rst);
    if (n > 0)        e_data = sb_q[0];
    else if (e_valid) e_data = {v.pc, v.inst};
    else              e_data = '0;
    if (known) begin
      check("count",      64'(count),      64'(n));
      check("empty",      64'(empty),      64'(n == 0));
      check("full",       64'(full),       64'(n == DEPTH));
      check("push_ready", 64'(push_ready), 64'(n < DEPTH));
      check("pop_valid",  64'(pop_valid),  64'(e_valid));
      check("pop_pc",     64'(pop_pc),     64'(e_data[63:32]));
      check("pop_inst",   64'(pop_inst),   64'(e_data[31:0]));
    end
    if (v.rst || v.flush) begin
      sb_q.delete();
    end else begin
      bypassed = BYP && (n == 0) && v.pv && v.pr;
      if (!bypassed) begin
        if (n > 0 && v.pr) void'(sb_q.pop_front());
        if (v.pv && n < DEPTH) sb_q.push_back({v.pc, v.inst});
      end
    end
    if (v.rst) known = 1'b1;
    @(posedge clk);
    #1;
    if (known) check("count_after_edge", 64'(count), 64'(v.exp_count));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;
    // Reset then idle.
    add(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    add(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    // Fill to full with decode stalled, then an ignored 5th push.
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, 32'(4 * i), 32'h2001_0001 + 32'(i), 0, i + 1, i + 1);
    add(0, 0, 1, 32'h10, 32'h2001_0005, 0, 4, 4);
    // Drain in order.
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 32'h0, 32'h0, 1, 3 - i, 3 - i);
    add(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    // Streaming push+pop every cycle across pointer wrap.
    for (int i = 0; i < 10; i++)
      add(0, 0, 1, 32'(4 * i), 32'h3000_0000 + 32'(i), 1, 1, 0);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    // Flush mid-stream: 0x4C must be discarded, 0x100 comes out first.
    add(0, 0, 1, 32'h40, 32'h4000_0040, 0, 1, 1);
    add(0, 0, 1, 32'h44, 32'h4000_0044, 0, 2, 2);
    add(0, 0, 1, 32'h48, 32'h4000_0048, 0, 3, 3);
    add(0, 1, 1, 32'h4C, 32'h4000_004C, 1, 0, 0);
    add(0, 0, 1, 32'h100, 32'h4000_0100, 0, 1, 1);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    // Reset mid-operation with a push pending.
    add(0, 0, 1, 32'h300, 32'h5000_0300, 0, 1, 1);
    add(0, 0, 1, 32'h304, 32'h5000_0304, 0, 2, 2);
    add(1, 0, 1, 32'h308, 32'h5000_0308, 1, 0, 0);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    // Fall-through candidate on an empty queue.
    add(0, 0, 1, 32'h200, 32'h8C22_0000, 1, 1, 0);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    // Flush on an empty queue with a push offered: nothing visible, nothing kept.
    add(0, 1, 1, 32'h500, 32'h6000_0500, 1, 0, 0);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Hand-written: full queue with simultaneous push and pop; push refused.
    for (int i = 0; i < 4; i++) begin
      hv = '{rst: 0, flush: 0, pv: 1, pc: 32'h700 + 32'(4 * i),
             inst: 32'h7000_0000 + 32'(i), pr: 0, exp_count: i + 1};
      step(hv);
    end
    hv = '{rst: 0, flush: 0, pv: 1, pc: 32'h710, inst: 32'h7000_0004, pr: 1, exp_count: 3};
    step(hv);
    // Refill one slot, then drain with decode always ready.
    hv = '{rst: 0, flush: 0, pv: 1, pc: 32'h714, inst: 32'h7000_0005, pr: 0, exp_count: 4};
    step(hv);
    for (int i = 0; i < 4; i++) begin
      hv = '{rst: 0, flush: 0, pv: 0, pc: 32'h0, inst: 32'h0, pr: 1, exp_count: 3 - i};
      step(hv);
    end
    hv = '{rst: 0, flush: 0, pv: 0, pc: 32'h0, inst: 32'h0, pr: 0, exp_count: 0};
    step(hv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the instruction-fetch stage and the decode stage.
- Buffers {pc, inst} pairs produced by fetch and hands them to decode on a valid/ready handshake.
- Backpressures fetch when full.
- Discards all in-flight entries on a jump or exception redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  redirect (jump taken or exception); empties queue.
- push_valid  input  1  fetch presents a valid pc/inst pair.
- push_pc  input  32  pc of fetched instruction.
- push_inst  input  32  fetched instruction word.
- push_ready  output  1  queue can accept a push this cycle.
- pop_valid  output  1  head entry is valid for decode.
- pop_pc  output  32  pc of head entry.
- pop_inst  output  32  instruction of head entry.
- pop_ready  input  1  decode consumes head this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH x 64 bits (pc, inst).
  - wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH.
  - count is a separate PTR_W+1 register.
- Reset (rst=1 at rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - pop_valid=0, pop_pc=0, pop_inst=0x00000000 (NOP), full=0, empty=1, push_ready=1.
  - Storage contents need not be cleared.
  - Reset mid-operation drops all entries; no pop occurs that cycle.
- Handshake:
  - push_ready = !full. This is combinational from count only and does not depend on pop_ready. A push into a full queue is never accepted, even if a pop happens in the same cycle.
  - A push happens when push_valid && push_ready: write entry at wr_ptr, wr_ptr+1.
  - A pop happens when pop_valid && pop_ready: rd_ptr+1.
  - count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Outputs:
  - pop_valid = !empty.
  - pop_pc/pop_inst come combinationally from entry[rd_ptr] when non-empty. They are forced to 0 when empty.
  - push_valid while push_ready=0 is ignored. Fetch must hold its pc/inst; no entry is written.
- Latency: without the optional feature, an entry pushed in cycle N is visible on pop_valid in cycle N+1.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Sets wr_ptr=rd_ptr=0 and count=0.
  - A push presented in the flush cycle is discarded.
  - A pop presented in the flush cycle has no effect on state; decode must ignore pop_* that cycle.
- Priority order: rst > flush > push/pop.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Data order is strictly FIFO.
- Overflow and underflow cannot occur by construction. A push is gated by push_ready and a pop by pop_valid.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined (fall-through):
  - If the queue is empty and push_valid=1, then pop_valid=1 in the same cycle and pop_pc/pop_inst=push_pc/push_inst.
  - If pop_ready=1 that cycle, nothing is written and the pointers and count are unchanged.
  - If pop_ready=0, the entry is written normally.
  - Flush still suppresses bypass: pop_valid=0 in the flush cycle.
- When not defined: no combinational path from push_* to pop_*; minimum latency is 1 cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, empty=1, full=0, push_ready=1, pop_valid=0, pop_inst=0x00000000.
- Fill and drain, DEPTH=4, pop_ready=0:
  - Push pc 0x0,0x4,0x8,0xC with inst 0x20010001..0x20010004 -> full=1, push_ready=0, count=4.
  - A 5th push of pc 0x10 is ignored.
  - Then pop_ready=1 for 4 cycles -> pops return pc 0x0,0x4,0x8,0xC in order, then empty=1.
- Wrap with streaming: push and pop every cycle for 10 cycles, pcs 0x0..0x24 step 4 -> count stays 1, pop order matches push order across pointer wrap (rd_ptr 3->0).
- Flush mid-stream:
  - Queue holds 3 entries (pc 0x40,0x44,0x48); flush=1 with push_valid=1 (pc 0x4C) -> next cycle count=0, empty=1; pc 0x4C never appears.
  - Subsequent push of pc 0x100 is popped first.
- Reset mid-operation: queue holds 2 entries and push_valid=1; rst=1 -> next cycle count=0, pop_valid=0; stale entries never appear.
- Bypass (IFQ_BYPASS_EN defined):
  - Empty queue, push pc 0x200 inst 0x8C220000, pop_ready=1 same cycle -> pop_valid=1 that cycle with the same pc/inst; count stays 0.
  - Without the macro -> pop_valid=0 that cycle, 1 the next.
